// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and limits for uart_tx_arbiter
package uart_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int PW = $clog2(MAX_REQ);
  localparam int DEF_TIMEOUT = 1024;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACCEPT    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_CLR  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HOLD      = 3'd5
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot selector, first request at or above i_ptr with wrap
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_any
);
  logic [N-1:0] w_rot, w_rot_gnt;
  // rotate so the pointer sits at bit 0, isolate lowest set bit, rotate back
  assign w_rot     = N'({i_req, i_req} >> i_ptr);
  assign w_rot_gnt = w_rot & (~w_rot + N'(1));
  assign o_gnt     = N'((({w_rot_gnt, w_rot_gnt} << i_ptr) >> N));
  assign o_any     = |i_req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to force release of an owner stalled mid-packet for TIMEOUT cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [7:0]           o_tx,
  output logic                 o_tx_start,
  input  logic                 i_tx_start_clear,
  input  logic                 i_tx_busy,
  output logic                 o_busy,
  output logic                 o_timeout
);
  state_t r_state, w_next;
  logic [NUM_REQ-1:0] r_grant, w_pick;
  logic [PW-1:0] r_ptr, w_owner, w_next_ptr;
  logic [7:0] r_tx, w_own_data;
  logic r_last, r_tx_start, r_timeout, w_any, w_own_valid, w_own_last, w_to_hit;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_any (w_any)
  );

  assign w_own_valid = |(i_req_valid & r_grant);
  assign w_own_last  = |(i_req_last & r_grant);
  assign w_next_ptr  = (w_owner == PW'(NUM_REQ - 1)) ? '0 : w_owner + PW'(1);

  always_comb begin
    w_owner    = '0;
    w_own_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_owner    |= r_grant[k] ? PW'(k) : '0;
      w_own_data |= r_grant[k] ? i_req_data[8*k +: 8] : '0;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign w_to_hit = (r_state == S_HOLD) && !w_own_valid && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (r_state == S_ACCEPT || w_to_hit) r_cnt <= '0;
    else if (r_state == S_HOLD && !w_own_valid) r_cnt <= r_cnt + CW'(1);
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = (w_any && !i_tx_busy) ? S_ACCEPT : S_IDLE;
      S_ACCEPT:    w_next = w_own_valid ? S_START : S_HOLD;
      S_START:     w_next = S_WAIT_CLR;
      S_WAIT_CLR:  w_next = i_tx_start_clear ? S_WAIT_DONE : S_WAIT_CLR;
      S_WAIT_DONE: w_next = i_tx_busy ? S_WAIT_DONE : (r_last ? S_IDLE : S_HOLD);
      S_HOLD:      w_next = w_own_valid ? S_ACCEPT : (w_to_hit ? S_IDLE : S_HOLD);
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_grant    <= '0;
      r_ptr      <= '0;
      r_tx       <= '0;
      r_last     <= 1'b0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_to_hit;
      case (r_state)
        S_IDLE: if (w_any && !i_tx_busy) r_grant <= w_pick;
        S_ACCEPT: if (w_own_valid) begin
          r_tx   <= w_own_data;
          r_last <= w_own_last;
        end
        S_START: r_tx_start <= 1'b1;
        S_WAIT_CLR: if (i_tx_start_clear) r_tx_start <= 1'b0;
        S_WAIT_DONE: if (!i_tx_busy && r_last) begin
          r_ptr   <= w_next_ptr;
          r_grant <= '0;
        end
        S_HOLD: if (w_to_hit) begin
          r_ptr   <= w_next_ptr;
          r_grant <= '0;
        end
        default: ;
      endcase
    end

  assign o_req_ready = (r_state == S_ACCEPT) ? (i_req_valid & r_grant) : '0;
  assign o_grant     = r_grant;
  assign o_tx        = r_tx;
  assign o_tx_start  = r_tx_start;
  assign o_busy      = r_state != S_IDLE;
  assign o_timeout   = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester queues and a simple UART transmitter model
module tb_uart_tx_arbiter;
  localparam int N = 3;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL = 10;
`else
  localparam int STALL = 20;
`endif
  typedef struct {logic [7:0] d; logic l;} beat_t;
  typedef struct {logic [7:0] d; logic [N-1:0] g;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] i_req_valid, i_req_last, o_req_ready, o_grant;
  logic [8*N-1:0] i_req_data;
  logic [7:0] o_tx;
  logic o_tx_start, i_tx_start_clear, i_tx_busy, o_busy, o_timeout;

  beat_t rq[N][$];
  exp_t sb[$];
  int pops[N];
  int checks = 0, passes = 0, to_cycles = 0;
  logic [N-1:0] pend = '0;
  logic prev_start = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .i_req_data       (i_req_data),
    .i_req_last       (i_req_last),
    .o_req_ready      (o_req_ready),
    .o_grant          (o_grant),
    .o_tx             (o_tx),
    .o_tx_start       (o_tx_start),
    .i_tx_start_clear (i_tx_start_clear),
    .i_tx_busy        (i_tx_busy),
    .o_busy           (o_busy),
    .o_timeout        (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic l);
    rq[k].push_back('{d, l});
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [N-1:0] g);
    sb.push_back('{d, g});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 3000 && (o_busy || i_tx_busy || sb.size() != 0 ||
           rq[0].size() + rq[1].size() + rq[2].size() != 0)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
    chk({name, "_idle"}, {o_busy, o_grant}, 0);
  endtask

  task automatic wait_tx_done(input string name);
    int n = 0;
    while (!i_tx_busy && n < 200) begin @(negedge clk); n++; end
    while (i_tx_busy && n < 400) begin @(negedge clk); n++; end
    chk({name, "_tx_done"}, i_tx_busy, 0);
  endtask

  // requester model: present queue heads, pop after an accepted ready pulse
  initial begin
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    for (int k = 0; k < N; k++) pops[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (pend[k] && rq[k].size() != 0) begin
          rq[k].delete(0);
          pops[k]++;
        end
        i_req_valid[k]        = rq[k].size() != 0;
        i_req_data[8*k +: 8]  = rq[k].size() != 0 ? rq[k][0].d : 8'h00;
        i_req_last[k]         = rq[k].size() != 0 && rq[k][0].l;
      end
    end
  end

  // transmitter model: latch 3 cycles after start, busy for 10 cycles
  initial begin
    i_tx_start_clear = 1'b0;
    i_tx_busy        = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (o_tx_start && !i_tx_busy) begin
        repeat (2) @(posedge clk);
        #1;
        i_tx_start_clear = 1'b1;
        i_tx_busy        = 1'b1;
        @(posedge clk);
        #1;
        i_tx_start_clear = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        i_tx_busy = 1'b0;
      end
    end
  end

  // monitor: invariants every cycle, scoreboard pop on each new start request
  initial forever begin
    exp_t e;
    @(negedge clk);
    pend = o_req_ready & i_req_valid;
    if (o_timeout) to_cycles++;
    chk("grant_onehot", {31'd0, $onehot0(o_grant)}, 1);
    chk("ready_owner", {29'd0, o_req_ready & ~o_grant}, 0);
`ifndef UART_ARB_TIMEOUT_EN
    chk("timeout_tied", {31'd0, o_timeout}, 0);
`endif
    if (o_tx_start && !prev_start) begin
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tx_byte", {24'd0, o_tx}, {24'd0, e.d});
        chk("tx_owner", {29'd0, o_grant}, {29'd0, e.g});
      end
    end
    prev_start = o_tx_start;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int p0, p2, n;
    repeat (3) @(negedge clk);
    chk("rst_grant", {29'd0, o_grant}, 0);
    chk("rst_ready", {29'd0, o_req_ready}, 0);
    chk("rst_tx", {24'd0, o_tx}, 0);
    chk("rst_start", {31'd0, o_tx_start}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_timeout", {31'd0, o_timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // two-byte packet from req0
    p0 = pops[0];
    send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b1);
    expect_tx(8'h41, 3'b001); expect_tx(8'h42, 3'b001);
    wait_idle("t1");
    chk("t1_ready_pulses", pops[0] - p0, 2);
    // pointer now 1: req1 wins over req0
    send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1);
    expect_tx(8'h11, 3'b010); expect_tx(8'h10, 3'b001);
    wait_idle("t1b");
    // fresh pointer: rotation across all three
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    send(0, 8'hA0, 1'b1); send(0, 8'hA0, 1'b1); send(1, 8'hB1, 1'b1); send(2, 8'hC2, 1'b1);
    expect_tx(8'hA0, 3'b001); expect_tx(8'hB1, 3'b010); expect_tx(8'hC2, 3'b100); expect_tx(8'hA0, 3'b001);
    wait_idle("t2");
    // req1 stalls mid-packet while req2 waits
    p2 = pops[2];
    send(1, 8'h51, 1'b0); send(2, 8'h61, 1'b1);
    expect_tx(8'h51, 3'b010);
    wait_tx_done("t3");
    repeat (STALL) @(negedge clk);
    chk("t3_hold_grant", {29'd0, o_grant}, 3'b010);
    chk("t3_other_waits", pops[2] - p2, 0);
    chk("t3_hold_busy", {31'd0, o_busy}, 1);
    send(1, 8'h52, 1'b1);
    expect_tx(8'h52, 3'b010); expect_tx(8'h61, 3'b100);
    wait_idle("t3");
    // pointer to 2, then req2 alone re-granted with wrap to 0
    send(1, 8'h71, 1'b1);
    expect_tx(8'h71, 3'b010);
    wait_idle("t4a");
    send(2, 8'h81, 1'b1); send(2, 8'h82, 1'b1);
    expect_tx(8'h81, 3'b100); expect_tx(8'h82, 3'b100);
    wait_idle("t4b");
    send(0, 8'h92, 1'b1); send(1, 8'h93, 1'b1);
    expect_tx(8'h92, 3'b001); expect_tx(8'h93, 3'b010);
    wait_idle("t4c");
    // asynchronous reset while waiting for the transmitter to latch
    send(0, 8'hA5, 1'b1);
    expect_tx(8'hA5, 3'b001);
    n = 0;
    while (!o_tx_start && n < 200) begin @(negedge clk); n++; end
    chk("t5_started", {31'd0, o_tx_start}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start", {31'd0, o_tx_start}, 0);
    chk("t5_rst_grant", {29'd0, o_grant}, 0);
    chk("t5_rst_tx", {24'd0, o_tx}, 0);
    chk("t5_rst_busy", {31'd0, o_busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'hB5, 1'b1); send(2, 8'hC5, 1'b1);
    expect_tx(8'hB5, 3'b001); expect_tx(8'hC5, 3'b100);
    wait_idle("t5");
    // owner stalls in HOLD with req1 waiting
    send(0, 8'hD0, 1'b0); send(1, 8'hD1, 1'b1);
    expect_tx(8'hD0, 3'b001);
`ifdef UART_ARB_TIMEOUT_EN
    expect_tx(8'hD1, 3'b010);
    wait_idle("t6");
    chk("t6_timeout_pulse", to_cycles, 1);
`else
    wait_tx_done("t6");
    repeat (40) @(negedge clk);
    chk("t6_hold_forever", {29'd0, o_grant}, 3'b001);
    chk("t6_no_timeout", to_cycles, 0);
    send(0, 8'hD2, 1'b1);
    expect_tx(8'hD2, 3'b001); expect_tx(8'hD1, 3'b010);
    wait_idle("t6");
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
